pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage. It holds the architectural fetch PC and selects the next PC from four sources: sequential increment, branch target, JALR ALU result, and trap vector. It also holds redirects that arrive while fetch is stalled, and blocks misaligned control-flow targets by diverting to the trap vector. It sits at the head of the fetch pipeline, feeding instruction-memory address and the IF/ID register.

## Interface
Parameters:
- XLEN, 32, address/PC width in bits (≥ 8)
- RESET_VECTOR, {XLEN{1'b0}}, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC; no update while high
- pc_src  in  2  00 sequential, 01 branch target, 10 JALR, 11 reserved (treated as 00)
- pc_target  in  XLEN  branch/JAL target
- alu_result  in  XLEN  JALR target (bit 0 ignored)
- trap  in  1  trap request; highest priority
- trap_vec  in  XLEN  trap handler address
- pc  out  XLEN  current fetch PC (registered)
- pc_plus_4  out  XLEN  pc + 4, combinational, modulo 2^XLEN
- redirect_pending  out  1  a redirect is held because of a stall
- misalign  out  1  one-cycle pulse: a misaligned target was rejected
- misalign_addr  out  XLEN  last rejected target (registered)

## Operation
- Candidate target per cycle, in priority order:
  1. trap=1 → trap_vec
  2. pc_src=01 → pc_target
  3. pc_src=10 → {alu_result[XLEN-1:1],1'b0}
  4. otherwise → sequential
- A redirect is any of the first three.
- Alignment check:
  - Trap vectors are not checked.
  - A branch or JALR target whose bit 1 is set (after the JALR bit-0 clear) is misaligned.
  - On a misaligned target: pc ← trap_vec, misalign pulses, misalign_addr ← the rejected target.
- Pending register: one entry holding a type (trap or normal) and a resolved target.
  - A redirect arriving while stall=1 is captured; redirect_pending=1.
  - A later redirect during the same stall overwrites the entry, except that a non-trap never overwrites a pending trap.
  - A misaligned branch/JALR captured during a stall is stored as a trap to trap_vec. misalign and misalign_addr update in the capture cycle.
- First cycle with stall=0:
  - A live trap beats the pending entry.
  - Otherwise the pending entry is applied and the live pc_src is ignored in that cycle.
  - The pending entry then clears.
- With no stall and no pending entry: a redirect loads its target; otherwise pc ← pc_plus_4.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - pc=RESET_VECTOR
  - redirect_pending=0
  - misalign=0
  - misalign_addr=0
- Reset mid-stall discards the pending entry.
- Latency: a redirect seen with stall=0 at edge N makes pc equal the target after edge N; the following fetch sees it in cycle N+1.
- A pending redirect applies at the first edge with stall=0.
- redirect_pending rises after the capture edge and falls after the apply edge.
- misalign is high for exactly the cycle after the rejecting edge. This holds even when stall=1.
- Wrap-around: sequential PC from 2^XLEN−4 goes to 0 with no flag.
- Simultaneous trap and pc_src≠00: the trap wins, and no misalign check is made on the ignored target.
- pc_src=11 behaves exactly like 00.

## Test plan
- Reset, then 3 free-running cycles, RESET_VECTOR=0x1000 → pc 0x1000, 0x1004, 0x1008, 0x100C; misalign=0.
- pc_src=01, pc_target=0x200 for one cycle → pc=0x200 next cycle, then 0x204.
- pc_src=10, alu_result=0x301 → pc=0x300; alu_result=0x302 → pc=trap_vec, misalign pulses 1 cycle, misalign_addr=0x302.
- Three cycles of stall=1 holding pc at 0x40:
  - Cycle 1: pc_src=01 target 0x80; cycle 2: trap with trap_vec=0xF00; cycle 3: pc_src=01 target 0x90.
  - Release stall → pc=0xF00 (a pending trap is not overwritten by the later branch), and redirect_pending is 1 then 0.
- pc=0xFFFF_FFFC, no redirect → pc=0x0, pc_plus_4=0x4.
- Pending redirect held, then rst_n pulsed low asynchronously between edges → pc=RESET_VECTOR immediately, redirect_pending=0, and sequential fetch follows after release.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with redirect selection, stall-held redirect and misaligned-target trapping
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            redirect_pending,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);
    logic            pend_valid, pend_trap;
    logic [XLEN-1:0] pend_tgt;
    logic [XLEN-1:0] tgt, res_tgt, next_pc;
    logic            is_br, redir, mis, res_trap, use_live;

    assign pc_plus_4        = pc + XLEN'(4);
    assign redirect_pending = pend_valid;

    always_comb begin
        is_br    = (pc_src == 2'b01) || (pc_src == 2'b10);
        tgt      = (pc_src == 2'b01) ? pc_target : {alu_result[XLEN-1:1], 1'b0};
        redir    = trap || is_br;
        // live pc_src is ignored on the cycle a held redirect is applied
        use_live = stall || !pend_valid;
        mis      = use_live && !trap && is_br && tgt[1];
        res_trap = trap || mis;
        res_tgt  = res_trap ? trap_vec : tgt;
        next_pc  = trap ? trap_vec : pend_valid ? pend_tgt : redir ? res_tgt : pc_plus_4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_VECTOR;
            pend_valid    <= 1'b0;
            pend_trap     <= 1'b0;
            pend_tgt      <= '0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= mis;
            if (mis) misalign_addr <= tgt;
            if (stall) begin
                // a held trap can only be replaced by another trap
                if (redir && (res_trap || !pend_valid || !pend_trap)) begin
                    pend_valid <= 1'b1;
                    pend_trap  <= res_trap;
                    pend_tgt   <= res_tgt;
                end
            end else begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized and directed checking of pc_gen against a behavioural fetch-PC model
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] pc_target = '0, alu_result = '0, trap_vec = '0;
    logic        trap = 1'b0;
    logic [31:0] pc, pc_plus_4, misalign_addr;
    logic        redirect_pending, misalign;

    int checks = 0, errors = 0;

    logic [31:0] m_pc = RV, m_ptgt = '0, m_maddr = '0;
    bit          m_pv = 0, m_pt = 0, m_mis = 0;

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src),
        .pc_target(pc_target), .alu_result(alu_result), .trap(trap),
        .trap_vec(trap_vec), .pc(pc), .pc_plus_4(pc_plus_4),
        .redirect_pending(redirect_pending), .misalign(misalign),
        .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_pv = 0; m_pt = 0; m_ptgt = '0; m_mis = 0; m_maddr = '0;
    endtask

    // what the PC must do at one rising edge, given the inputs presented
    task automatic model_edge();
        bit          br;
        logic [31:0] t;
        br    = (pc_src == 2'd1) || (pc_src == 2'd2);
        t     = (pc_src == 2'd1) ? pc_target : (alu_result & 32'hFFFF_FFFE);
        m_mis = 0;
        if (stall) begin
            if (trap) begin
                m_pv = 1; m_pt = 1; m_ptgt = trap_vec;
            end else if (br && t[1]) begin
                m_mis = 1; m_maddr = t; m_pv = 1; m_pt = 1; m_ptgt = trap_vec;
            end else if (br && !(m_pv && m_pt)) begin
                m_pv = 1; m_pt = 0; m_ptgt = t;
            end
        end else begin
            if (trap) m_pc = trap_vec;
            else if (m_pv) m_pc = m_ptgt;
            else if (br && t[1]) begin m_pc = trap_vec; m_mis = 1; m_maddr = t; end
            else if (br) m_pc = t;
            else m_pc = m_pc + 32'd4;
            m_pv = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic drive(input bit s, input logic [1:0] src, input logic [31:0] tg,
                         input logic [31:0] alu, input bit tr, input logic [31:0] tv);
        stall = s; pc_src = src; pc_target = tg; alu_result = alu; trap = tr; trap_vec = tv;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pc", pc, m_pc);
            chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
            chk("redirect_pending", 32'(redirect_pending), 32'(m_pv));
            chk("misalign", 32'(misalign), 32'(m_mis));
            chk("misalign_addr", misalign_addr, m_maddr);
        end
    end

    initial begin
        model_reset();
        #12;
        chk("reset_pc", pc, 32'h1000);
        chk("reset_pending", 32'(redirect_pending), 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        chk("reset_maddr", misalign_addr, 32'd0);
        rst_n = 1'b1;
        cyc(); chk("seq1", pc, 32'h1004);
        cyc(); chk("seq2", pc, 32'h1008);
        cyc(); chk("seq3", pc, 32'h100C);
        chk("seq_misalign", 32'(misalign), 32'd0);

        drive(0, 2'd1, 32'h200, 0, 0, 32'hF00); cyc(); chk("branch", pc, 32'h200);
        drive(0, 2'd0, 0, 0, 0, 32'hF00);       cyc(); chk("after_branch", pc, 32'h204);
        drive(0, 2'd2, 0, 32'h301, 0, 32'hF00); cyc(); chk("jalr", pc, 32'h300);
        drive(0, 2'd2, 0, 32'h302, 0, 32'hF00); cyc();
        chk("jalr_mis_pc", pc, 32'hF00);
        chk("jalr_mis_flag", 32'(misalign), 32'd1);
        chk("jalr_mis_addr", misalign_addr, 32'h302);
        drive(0, 2'd0, 0, 0, 0, 32'hF00);       cyc();
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_seq", pc, 32'hF04);

        drive(0, 2'd1, 32'h40, 0, 0, 32'hF00);  cyc(); chk("to_40", pc, 32'h40);
        drive(1, 2'd1, 32'h80, 0, 0, 32'hF00);  cyc();
        chk("stall_hold1", pc, 32'h40);
        chk("pend_rise", 32'(redirect_pending), 32'd1);
        drive(1, 2'd0, 0, 0, 1, 32'hF00);       cyc();
        drive(1, 2'd1, 32'h90, 0, 0, 32'hF00);  cyc();
        chk("stall_hold3", pc, 32'h40);
        chk("pend_held", 32'(redirect_pending), 32'd1);
        drive(0, 2'd0, 0, 0, 0, 32'hF00);       cyc();
        chk("pend_trap_apply", pc, 32'hF00);
        chk("pend_fall", 32'(redirect_pending), 32'd0);

        drive(0, 2'd1, 32'hFFFF_FFFC, 0, 0, 32'hF00); cyc();
        drive(0, 2'd3, 32'h1234, 0, 0, 32'hF00);      cyc();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_p4", pc_plus_4, 32'h4);
        chk("wrap_misalign", 32'(misalign), 32'd0);

        drive(1, 2'd1, 32'h500, 0, 0, 32'hF00); cyc();
        chk("pend_before_rst", 32'(redirect_pending), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", pc, 32'h1000);
        chk("async_rst_pend", 32'(redirect_pending), 32'd0);
        #3 rst_n = 1'b1;
        drive(0, 2'd0, 0, 0, 0, 32'hF00); cyc();
        chk("post_rst_seq", pc, 32'h1004);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg, alu, tv;
            tg  = $urandom & 32'hFFFF_FFFC | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
            alu = $urandom & 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            tv  = $urandom & 32'hFFFF_FFFC;
            drive($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), tg, alu,
                  $urandom_range(0, 9) == 0, tv);
            cyc();
        end
        drive(0, 2'd0, 0, 0, 0, 0);
        cyc(); cyc();
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
